rv32_branch_predictor: RTL and testbench

- Parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters.
- Fetch stage performs a same-cycle lookup to obtain a predicted next PC.
- Execute stage writes back resolved outcomes: branch op, taken flag, target from the PC mux.
- Successor to the purely combinational taken/target logic: adds state, so prediction and learning replace the fixed PC+4 fall-through.

---
 rtl/rv32_branch_predictor_pkg.sv | 20 ++
 rtl/rv32_branch_predictor_counter.sv | 19 +
 rtl/rv32_branch_predictor.sv | 123 ++++++++++++
 tb/tb_rv32_branch_predictor.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_branch_predictor_pkg.sv
// Shared branch-op encodings and 2-bit direction counter constants for the
// RV32 branch predictor.
package rv32_branch_predictor_pkg;

  localparam logic [1:0] RV32_BRANCH_OP_NEVER    = 2'b00;
  localparam logic [1:0] RV32_BRANCH_OP_ZERO     = 2'b01;
  localparam logic [1:0] RV32_BRANCH_OP_NON_ZERO = 2'b10;
  localparam logic [1:0] RV32_BRANCH_OP_ALWAYS   = 2'b11;

  localparam logic [1:0] RV32_BRANCH_CTR_STRONG_NOT_TAKEN = 2'b00;
  localparam logic [1:0] RV32_BRANCH_CTR_WEAK_NOT_TAKEN   = 2'b01;
  localparam logic [1:0] RV32_BRANCH_CTR_WEAK_TAKEN       = 2'b10;
  localparam logic [1:0] RV32_BRANCH_CTR_STRONG_TAKEN     = 2'b11;

  // Upper counter bit carries the direction prediction.
  function automatic logic ctr_predicts_taken(input logic [1:0] ctr);
    return ctr[1];
  endfunction

endpackage

// File: rtl/rv32_branch_predictor_counter.sv
// Combinational next-state for a 2-bit saturating branch direction counter.
module rv32_branch_predictor_counter
  import rv32_branch_predictor_pkg::*;
(
  input  logic [1:0] ctr_in,
  input  logic       taken_in,
  output logic [1:0] ctr_out
);

  always_comb begin
    ctr_out = ctr_in;
    if (taken_in) begin
      if (ctr_in != RV32_BRANCH_CTR_STRONG_TAKEN) ctr_out = ctr_in + 2'd1;
    end else begin
      if (ctr_in != RV32_BRANCH_CTR_STRONG_NOT_TAKEN) ctr_out = ctr_in - 2'd1;
    end
  end

endmodule

// File: rtl/rv32_branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters: same-cycle
// fetch lookup, registered execute-stage update, synchronous flush.
module rv32_branch_predictor
  import rv32_branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        lookup_valid_in,
  input  logic [31:0] lookup_pc_in,
  output logic        predict_taken_out,
  output logic [31:0] predict_pc_out,
  input  logic        update_valid_in,
  input  logic [1:0]  update_op_in,
  input  logic [31:0] update_pc_in,
  input  logic        update_taken_in,
  input  logic [31:0] update_target_in,
  input  logic        flush_in
);

  localparam int unsigned INDEX_BITS = $clog2(ENTRIES);
  localparam int unsigned TAG_BITS   = 30 - INDEX_BITS;

  if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : gen_bad_entries
    $error("ENTRIES must be a power of two and at least 2");
  end

  // Only valid is reset; the payload fields are meaningless until allocated.
  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [30:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  // Lookup
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [TAG_BITS-1:0]   lookup_tag;
  logic                  lookup_hit;
  logic [31:0]           lookup_pc_plus4;

  assign lookup_idx      = lookup_pc_in[INDEX_BITS+1:2];
  assign lookup_tag      = lookup_pc_in[31:INDEX_BITS+2];
  assign lookup_pc_plus4 = lookup_pc_in + 32'd4;
  assign lookup_hit      = lookup_valid_in && valid_q[lookup_idx] &&
                           (tag_q[lookup_idx] == lookup_tag);

  assign predict_taken_out = lookup_hit && ctr_predicts_taken(ctr_q[lookup_idx]);
  assign predict_pc_out    = predict_taken_out ? {target_q[lookup_idx], 1'b0}
                                               : lookup_pc_plus4;

  // Update
  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0]   upd_tag;
  logic                  upd_hit;
  logic [1:0]            upd_ctr_next;
  logic                  wr_en;
  logic                  wr_alloc;
  logic                  wr_target;
  logic [1:0]            wr_ctr;

  assign upd_idx = update_pc_in[INDEX_BITS+1:2];
  assign upd_tag = update_pc_in[31:INDEX_BITS+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  rv32_branch_predictor_counter u_counter (
    .ctr_in   (ctr_q[upd_idx]),
    .taken_in (update_taken_in),
    .ctr_out  (upd_ctr_next)
  );

  always_comb begin
    wr_en     = 1'b0;
    wr_alloc  = 1'b0;
    wr_target = 1'b0;
    wr_ctr    = upd_ctr_next;
    // Flush takes priority: a coincident update is dropped.
    if (update_valid_in && !flush_in) begin
      unique case (update_op_in)
        RV32_BRANCH_OP_ALWAYS: begin
          wr_en     = 1'b1;
          wr_alloc  = 1'b1;
          wr_target = 1'b1;
          wr_ctr    = RV32_BRANCH_CTR_STRONG_TAKEN;
        end
        RV32_BRANCH_OP_ZERO, RV32_BRANCH_OP_NON_ZERO: begin
          if (upd_hit) begin
            wr_en     = 1'b1;
            wr_target = update_taken_in;
          end else if (update_taken_in) begin
            wr_en     = 1'b1;
            wr_alloc  = 1'b1;
            wr_target = 1'b1;
            wr_ctr    = RV32_BRANCH_CTR_WEAK_TAKEN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (flush_in) begin
      valid_q <= '0;
    end else if (wr_en && wr_alloc) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_alloc)  tag_q[upd_idx]    <= upd_tag;
      if (wr_target) target_q[upd_idx] <= update_target_in[31:1];
      ctr_q[upd_idx] <= wr_ctr;
    end
  end

  // Word-aligned PCs and half-word-aligned targets never use these bits.
  logic unused_low_bits;
  assign unused_low_bits = ^{lookup_pc_in[1:0], update_pc_in[1:0], update_target_in[0]};

endmodule

// File: tb/tb_rv32_branch_predictor.sv
// Directed self-checking bench for rv32_branch_predictor (ENTRIES=64).
module tb_rv32_branch_predictor;
  import rv32_branch_predictor_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        lookup_valid_in;
  logic [31:0] lookup_pc_in;
  logic        predict_taken_out;
  logic [31:0] predict_pc_out;
  logic        update_valid_in;
  logic [1:0]  update_op_in;
  logic [31:0] update_pc_in;
  logic        update_taken_in;
  logic [31:0] update_target_in;
  logic        flush_in;

  int n_cmp = 0;
  int n_bad = 0;

  rv32_branch_predictor #(.ENTRIES(64)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .lookup_valid_in   (lookup_valid_in),
    .lookup_pc_in      (lookup_pc_in),
    .predict_taken_out (predict_taken_out),
    .predict_pc_out    (predict_pc_out),
    .update_valid_in   (update_valid_in),
    .update_op_in      (update_op_in),
    .update_pc_in      (update_pc_in),
    .update_taken_in   (update_taken_in),
    .update_target_in  (update_target_in),
    .flush_in          (flush_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one update across a rising edge, then deasserts it.
  task automatic upd(input logic [1:0] op, input logic [31:0] pc, input logic taken,
                     input logic [31:0] target, input logic flush);
    @(negedge clk);
    update_valid_in  = 1'b1;
    update_op_in     = op;
    update_pc_in     = pc;
    update_taken_in  = taken;
    update_target_in = target;
    flush_in         = flush;
    @(posedge clk);
    #1;
    update_valid_in = 1'b0;
    flush_in        = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    lookup_valid_in = 1'b1;
    lookup_pc_in    = pc;
    #1;
  endtask

  task automatic test_reset;
    look(32'h0000_0100);
    n_cmp++;
    if (predict_taken_out !== 1'b0 || predict_pc_out !== 32'h0000_0104) begin
      n_bad++;
      $display("FAIL reset_0x100: got %b/%h want 0/00000104", predict_taken_out, predict_pc_out);
    end
    look(32'hFFFF_FFFC);
    n_cmp++;
    if (predict_taken_out !== 1'b0 || predict_pc_out !== 32'h0000_0000) begin
      n_bad++;
      $display("FAIL reset_wrap: got %b/%h want 0/00000000", predict_taken_out, predict_pc_out);
    end
  endtask

  task automatic test_counter;
    // Each step: taken flag of the conditional update, then expected prediction.
    logic       tk  [11] = '{1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1};
    logic       ept [11] = '{1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 1};
    for (int i = 0; i < 11; i++) begin
      upd(RV32_BRANCH_OP_ZERO, 32'h0000_0100, tk[i], 32'h0000_0080, 1'b0);
      look(32'h0000_0100);
      n_cmp++;
      if (predict_taken_out !== ept[i] ||
          predict_pc_out !== (ept[i] ? 32'h0000_0080 : 32'h0000_0104)) begin
        n_bad++;
        $display("FAIL counter_step%0d: got %b/%h want %b/%h", i, predict_taken_out,
                 predict_pc_out, ept[i], ept[i] ? 32'h0000_0080 : 32'h0000_0104);
      end
    end
    // ctr now 10; a taken hit moves it to 11 and rewrites the target.
    upd(RV32_BRANCH_OP_NON_ZERO, 32'h0000_0100, 1'b1, 32'h0000_0090, 1'b0);
    upd(RV32_BRANCH_OP_NON_ZERO, 32'h0000_0100, 1'b0, 32'h0000_0070, 1'b0);
    look(32'h0000_0100);
    n_cmp++;
    if (predict_taken_out !== 1'b1 || predict_pc_out !== 32'h0000_0090) begin
      n_bad++;
      $display("FAIL target_rewrite: got %b/%h want 1/00000090", predict_taken_out, predict_pc_out);
    end
    lookup_valid_in = 1'b0;
    #1;
    n_cmp++;
    if (predict_taken_out !== 1'b0 || predict_pc_out !== 32'h0000_0104) begin
      n_bad++;
      $display("FAIL lookup_invalid: got %b/%h want 0/00000104", predict_taken_out, predict_pc_out);
    end
  endtask

  task automatic test_always_never;
    upd(RV32_BRANCH_OP_ALWAYS, 32'h0000_0040, 1'b1, 32'h0000_1000, 1'b0);
    look(32'h0000_0040);
    n_cmp++;
    if (predict_taken_out !== 1'b1 || predict_pc_out !== 32'h0000_1000) begin
      n_bad++;
      $display("FAIL always_alloc: got %b/%h want 1/00001000", predict_taken_out, predict_pc_out);
    end
    // Strong taken survives one not-taken update.
    upd(RV32_BRANCH_OP_ZERO, 32'h0000_0040, 1'b0, 32'h0000_0000, 1'b0);
    look(32'h0000_0040);
    n_cmp++;
    if (predict_taken_out !== 1'b1 || predict_pc_out !== 32'h0000_1000) begin
      n_bad++;
      $display("FAIL always_strong: got %b/%h want 1/00001000", predict_taken_out, predict_pc_out);
    end
    upd(RV32_BRANCH_OP_NEVER, 32'h0000_0044, 1'b1, 32'h0000_2000, 1'b0);
    look(32'h0000_0044);
    n_cmp++;
    if (predict_taken_out !== 1'b0 || predict_pc_out !== 32'h0000_0048) begin
      n_bad++;
      $display("FAIL never_noalloc: got %b/%h want 0/00000048", predict_taken_out, predict_pc_out);
    end
    upd(RV32_BRANCH_OP_ZERO, 32'h0000_0048, 1'b0, 32'h0000_3000, 1'b0);
    look(32'h0000_0048);
    n_cmp++;
    if (predict_taken_out !== 1'b0 || predict_pc_out !== 32'h0000_004C) begin
      n_bad++;
      $display("FAIL nt_miss_noalloc: got %b/%h want 0/0000004c", predict_taken_out, predict_pc_out);
    end
    upd(RV32_BRANCH_OP_ALWAYS, 32'hFFFF_FFFC, 1'b1, 32'h0000_0010, 1'b0);
    look(32'hFFFF_FFFC);
    n_cmp++;
    if (predict_taken_out !== 1'b1 || predict_pc_out !== 32'h0000_0010) begin
      n_bad++;
      $display("FAIL always_top: got %b/%h want 1/00000010", predict_taken_out, predict_pc_out);
    end
  endtask

  task automatic test_same_cycle;
    // Entry 0x100 holds ctr 10, target 0x90.
    @(negedge clk);
    lookup_valid_in  = 1'b1;
    lookup_pc_in     = 32'h0000_0100;
    update_valid_in  = 1'b1;
    update_op_in     = RV32_BRANCH_OP_ZERO;
    update_pc_in     = 32'h0000_0100;
    update_taken_in  = 1'b0;
    update_target_in = 32'h0000_0000;
    #1;
    n_cmp++;
    if (predict_taken_out !== 1'b1 || predict_pc_out !== 32'h0000_0090) begin
      n_bad++;
      $display("FAIL same_cycle_old: got %b/%h want 1/00000090", predict_taken_out, predict_pc_out);
    end
    @(posedge clk);
    #1;
    update_valid_in = 1'b0;
    #1;
    n_cmp++;
    if (predict_taken_out !== 1'b0 || predict_pc_out !== 32'h0000_0104) begin
      n_bad++;
      $display("FAIL same_cycle_new: got %b/%h want 0/00000104", predict_taken_out, predict_pc_out);
    end
  endtask

  task automatic test_alias;
    upd(RV32_BRANCH_OP_ZERO, 32'h0000_0100, 1'b1, 32'h0000_0090, 1'b0);
    look(32'h0000_0200);
    n_cmp++;
    if (predict_taken_out !== 1'b0 || predict_pc_out !== 32'h0000_0204) begin
      n_bad++;
      $display("FAIL alias_miss: got %b/%h want 0/00000204", predict_taken_out, predict_pc_out);
    end
    upd(RV32_BRANCH_OP_NON_ZERO, 32'h0000_0200, 1'b1, 32'h0000_0300, 1'b0);
    look(32'h0000_0200);
    n_cmp++;
    if (predict_taken_out !== 1'b1 || predict_pc_out !== 32'h0000_0300) begin
      n_bad++;
      $display("FAIL alias_replace: got %b/%h want 1/00000300", predict_taken_out, predict_pc_out);
    end
    look(32'h0000_0100);
    n_cmp++;
    if (predict_taken_out !== 1'b0 || predict_pc_out !== 32'h0000_0104) begin
      n_bad++;
      $display("FAIL alias_evicted: got %b/%h want 0/00000104", predict_taken_out, predict_pc_out);
    end
  endtask

  task automatic test_flush;
    logic [31:0] pcs [3] = '{32'h0000_0040, 32'h0000_0200, 32'h0000_0100};
    upd(RV32_BRANCH_OP_ZERO, 32'h0000_0100, 1'b1, 32'h0000_0500, 1'b1);
    for (int i = 0; i < 3; i++) begin
      look(pcs[i]);
      n_cmp++;
      if (predict_taken_out !== 1'b0 || predict_pc_out !== pcs[i] + 32'd4) begin
        n_bad++;
        $display("FAIL flush_pc%h: got %b/%h want 0/%h", pcs[i], predict_taken_out,
                 predict_pc_out, pcs[i] + 32'd4);
      end
    end
  endtask

  task automatic test_async_reset;
    upd(RV32_BRANCH_OP_ALWAYS, 32'h0000_0040, 1'b1, 32'h0000_1000, 1'b0);
    upd(RV32_BRANCH_OP_ALWAYS, 32'h0000_0200, 1'b1, 32'h0000_0300, 1'b0);
    look(32'h0000_0040);
    n_cmp++;
    if (predict_taken_out !== 1'b1 || predict_pc_out !== 32'h0000_1000) begin
      n_bad++;
      $display("FAIL pre_reset_hit: got %b/%h want 1/00001000", predict_taken_out, predict_pc_out);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (predict_taken_out !== 1'b0 || predict_pc_out !== 32'h0000_0044) begin
      n_bad++;
      $display("FAIL async_reset: got %b/%h want 0/00000044", predict_taken_out, predict_pc_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
    look(32'h0000_0200);
    n_cmp++;
    if (predict_taken_out !== 1'b0 || predict_pc_out !== 32'h0000_0204) begin
      n_bad++;
      $display("FAIL post_reset_miss: got %b/%h want 0/00000204", predict_taken_out, predict_pc_out);
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    lookup_valid_in  = 1'b0;
    lookup_pc_in     = '0;
    update_valid_in  = 1'b0;
    update_op_in     = RV32_BRANCH_OP_NEVER;
    update_pc_in     = '0;
    update_taken_in  = 1'b0;
    update_target_in = '0;
    flush_in         = 1'b0;
    #12;
    reset_n = 1'b1;
    test_reset();
    test_counter();
    test_always_never();
    test_same_cycle();
    test_alias();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
